parallel_to_serial: RTL and testbench

- Transmit-side counterpart of the host-link byte receiver.
- Accepts one N-bit result word (e.g. the final modular-exponentiation output) over a ready/valid handshake.
- Splits the word into N/8 bytes, most-significant byte first, and drives them one at a time into the UART transmitter. This is the same byte order the receiver uses when it assembles words by left-shifting.
- Sits between the exponentiation datapath and the UART TX, and reports completion of each word with a one-cycle `done` pulse.

---
 rtl/parallel_to_serial.sv | 100 ++++++++++
 tb/tb_parallel_to_serial.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/parallel_to_serial.sv
// Serializes one N-bit word into N/8 bytes, MSB first, for a UART transmitter.
// Handshake: a word moves when in_valid && in_ready on a rising clk edge; in_ready is high only in IDLE.
module parallel_to_serial #(
   parameter int N          = 32,
   parameter int NBYTES     = 4,
   parameter int NBYTESlog2 = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   input  logic [N-1:0]    in_data,
   output logic            in_ready,
   output logic [7:0]      tx_byte,
   output logic            tx_start,
   input  logic            tx_busy,
   output logic            done,
   output logic [1:0]      dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_GUARD = 2'd2,
      S_WAIT  = 2'd3
   } state_t;

   localparam logic [NBYTESlog2-1:0] LAST_CNT = NBYTESlog2'(NBYTES - 1);
   localparam logic [NBYTESlog2-1:0] CNT_ONE  = NBYTESlog2'(1);

   state_t                  r_state;
   state_t                  w_state_nxt;
   logic [N-1:0]            r_sreg;
   logic [NBYTESlog2-1:0]   r_cnt;
   logic                    r_tx_start;
   logic                    r_done;
   logic                    w_load;
   logic                    w_advance;
   logic                    w_finish;
   logic                    w_last;

   assign w_last = (r_cnt == LAST_CNT);

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_advance   = 1'b0;
      w_finish    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (in_valid) begin
               w_load      = 1'b1;
               w_state_nxt = S_START;
            end
         end
         S_START: w_state_nxt = S_GUARD;
         // The UART raises busy one cycle after start, so it is not looked at here.
         S_GUARD: w_state_nxt = S_WAIT;
         S_WAIT: begin
            if (!tx_busy) begin
               if (w_last) begin
                  w_finish    = 1'b1;
                  w_state_nxt = S_IDLE;
               end else begin
                  w_advance   = 1'b1;
                  w_state_nxt = S_START;
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_sreg     <= '0;
         r_cnt      <= '0;
         r_tx_start <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_tx_start <= (w_state_nxt == S_START);
         r_done     <= w_finish;
         if (w_load) begin
            r_sreg <= in_data;
            r_cnt  <= '0;
         end else if (w_advance) begin
            r_sreg <= r_sreg << 8;
            r_cnt  <= r_cnt + CNT_ONE;
         end
      end
   end

   assign in_ready  = (r_state == S_IDLE);
   assign tx_byte   = r_sreg[N-1 -: 8];
   assign tx_start  = r_tx_start;
   assign done      = r_done;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_parallel_to_serial.sv
// Directed bench for parallel_to_serial: UART busy model, byte monitor and
// left-shift word reassembly, with hand-computed byte sequences and timing.
module tb_parallel_to_serial;

   localparam int N = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic [N-1:0]  in_data = '0;
   logic          in_ready;
   logic [7:0]    tx_byte;
   logic          tx_start;
   logic          tx_busy;
   logic          done;
   logic [1:0]    dbg_state;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int uart_b   = 0;
   int busy_cnt = 0;

   int            start_q[$];
   logic [7:0]    byte_q[$];
   int            done_q[$];
   logic [N-1:0]  rx_q[$];
   logic [N-1:0]  exp_q[$];
   logic [N-1:0]  asm_word = '0;
   int            asm_cnt  = 0;

   parallel_to_serial #(.N(N), .NBYTES(4), .NBYTESlog2(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .tx_byte   (tx_byte),
      .tx_start  (tx_start),
      .tx_busy   (tx_busy),
      .done      (done),
      .dbg_state (dbg_state)
   );

   // clock / reset block
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   initial begin
      #800000;
      $display("FAIL watchdog: simulation time limit reached, got running expected finished");
      $fatal(1, "watchdog");
   end

   // UART model: busy for uart_b cycles starting the cycle after tx_start
   always @(posedge clk) begin
      if (tx_start === 1'b1) busy_cnt <= uart_b;
      else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
   end
   assign tx_busy = (busy_cnt != 0);

   // monitor and receive-side word assembler
   always @(negedge clk) begin
      if (rst) asm_cnt = 0;
      if (tx_start === 1'b1) begin
         start_q.push_back(cyc);
         byte_q.push_back(tx_byte);
         if (!rst) begin
            asm_word = {asm_word[N-9:0], tx_byte};
            asm_cnt++;
            if (asm_cnt == N/8) begin
               rx_q.push_back(asm_word);
               asm_cnt = 0;
            end
         end
      end
      if (done === 1'b1) done_q.push_back(cyc);
   end

   // scoreboard check
   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // driver tasks
   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic clear_q();
      start_q.delete();
      byte_q.delete();
      done_q.delete();
      rx_q.delete();
   endtask

   task automatic wait_ready();
      int k = 0;
      while (in_ready !== 1'b1 && k < 500) begin
         tick();
         k++;
      end
      check_eq("ready_timeout", {31'd0, in_ready}, 32'd1);
   endtask

   task automatic send_word(input logic [N-1:0] w, output int acc);
      wait_ready();
      in_valid = 1'b1;
      in_data  = w;
      tick();
      acc      = cyc;
      in_valid = 1'b0;
   endtask

   task automatic wait_done(input int n);
      int k = 0;
      while (done_q.size() < n && k < 2000) begin
         tick();
         k++;
      end
      check_eq("done_timeout", done_q.size(), n);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic check_bytes4(input string tag, input int base,
                               input logic [7:0] b0, input logic [7:0] b1,
                               input logic [7:0] b2, input logic [7:0] b3);
      logic [7:0] e[4];
      e = '{b0, b1, b2, b3};
      for (int i = 0; i < 4; i++) begin
         if (base + i < byte_q.size())
            check_eq($sformatf("%s_byte%0d", tag, i), byte_q[base + i], e[i]);
         else
            check_eq($sformatf("%s_byte%0d_missing", tag, i), byte_q.size(), base + i + 1);
      end
   endtask

   task automatic check_spacing(input string tag, input int base, input int gap);
      for (int i = base + 1; i < base + 4 && i < start_q.size(); i++)
         check_eq($sformatf("%s_gap%0d", tag, i), start_q[i] - start_q[i-1], gap);
   endtask

   int acc;
   int acc2;
   int k;
   logic [N-1:0] w;

   initial begin
      // reset held with a pending word on the input
      rst      = 1'b1;
      in_valid = 1'b1;
      in_data  = 32'hFFFF_FFFF;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_eq("rst_tx_start", {31'd0, tx_start}, 32'd0);
         check_eq("rst_done", {31'd0, done}, 32'd0);
         check_eq("rst_tx_byte", {24'd0, tx_byte}, 32'h00);
      end
      rst      = 1'b0;
      in_valid = 1'b0;
      tick();
      check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);
      check_eq("rst_state", {30'd0, dbg_state}, 32'd0);
      check_eq("rst_no_start", start_q.size(), 0);

      // single word, UART busy 10 cycles
      clear_q();
      uart_b = 10;
      send_word(32'hDEAD_BEEF, acc);
      wait_done(1);
      idle(20);
      check_eq("w1_starts", start_q.size(), 4);
      if (start_q.size() > 0) check_eq("w1_first_start", start_q[0], acc);
      check_bytes4("w1", 0, 8'hDE, 8'hAD, 8'hBE, 8'hEF);
      check_spacing("w1", 0, 12);
      check_eq("w1_dones", done_q.size(), 1);
      if (start_q.size() == 4 && done_q.size() > 0)
         check_eq("w1_done_lat", done_q[0] - start_q[3], 12);

      // zero-latency UART
      clear_q();
      uart_b = 0;
      send_word(32'h0102_0304, acc);
      wait_done(1);
      idle(10);
      check_eq("w2_starts", start_q.size(), 4);
      check_bytes4("w2", 0, 8'h01, 8'h02, 8'h03, 8'h04);
      check_spacing("w2", 0, 3);
      if (done_q.size() > 0) check_eq("w2_done_at", done_q[0], acc + 12);

      // input changes while busy are ignored; new word taken in the done cycle
      clear_q();
      uart_b = 2;
      wait_ready();
      in_valid = 1'b1;
      in_data  = 32'h1122_3344;
      tick();
      acc = cyc;
      idle(5);
      in_data = 32'h55AA_55AA;
      k = 0;
      while (done_q.size() == 0 && k < 500) begin
         tick();
         k++;
      end
      check_eq("w3_first_done", done_q.size(), 1);
      check_eq("w3_ready_at_done", {31'd0, in_ready}, 32'd1);
      check_eq("w3_no_early_accept", start_q.size(), 4);
      tick();
      acc2     = cyc;
      in_valid = 1'b0;
      wait_done(2);
      idle(10);
      check_eq("w3_starts", start_q.size(), 8);
      check_bytes4("w3a", 0, 8'h11, 8'h22, 8'h33, 8'h44);
      check_bytes4("w3b", 4, 8'h55, 8'hAA, 8'h55, 8'hAA);
      if (start_q.size() > 4 && done_q.size() > 0) begin
         check_eq("w3_turnaround", start_q[4], done_q[0] + 1);
         check_eq("w3_second_start", start_q[4], acc2);
      end
      check_spacing("w3b", 4, 4);

      // reset during WAIT of byte 1
      clear_q();
      uart_b = 4;
      send_word(32'hCAFE_F00D, acc);
      k = 0;
      while (start_q.size() < 2 && k < 200) begin
         tick();
         k++;
      end
      tick();
      tick();
      check_eq("w4_in_wait", {30'd0, dbg_state}, 32'd3);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_eq("w4_ready", {31'd0, in_ready}, 32'd1);
      check_eq("w4_tx_start", {31'd0, tx_start}, 32'd0);
      check_eq("w4_done", {31'd0, done}, 32'd0);
      check_eq("w4_tx_byte", {24'd0, tx_byte}, 32'h00);
      idle(20);
      check_eq("w4_no_more_starts", start_q.size(), 2);
      check_eq("w4_no_done", done_q.size(), 0);
      clear_q();
      send_word(32'h1234_5678, acc);
      wait_done(1);
      idle(10);
      check_eq("w5_starts", start_q.size(), 4);
      check_bytes4("w5", 0, 8'h12, 8'h34, 8'h56, 8'h78);
      check_spacing("w5", 0, 6);
      if (start_q.size() == 4 && done_q.size() > 0)
         check_eq("w5_done_lat", done_q[0] - start_q[3], 6);
      check_eq("w5_rx_count", rx_q.size(), 1);
      if (rx_q.size() > 0) check_eq("w5_rx_word", rx_q[0], 32'h1234_5678);

      // loopback through the byte assembler, first word all zeros
      clear_q();
      exp_q.delete();
      for (int i = 0; i < 100; i++) begin
         w      = (i == 0) ? 32'h0 : $urandom;
         uart_b = $urandom_range(0, 3);
         send_word(w, acc);
         exp_q.push_back(w);
         wait_done(i + 1);
      end
      idle(10);
      check_eq("lb_words", rx_q.size(), 100);
      check_eq("lb_dones", done_q.size(), 100);
      check_eq("lb_bytes", byte_q.size(), 400);
      while (exp_q.size() > 0 && rx_q.size() > 0)
         check_eq("lb_word", rx_q.pop_front(), exp_q.pop_front());

      // final report
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
